// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 field layout, special encodings and engine state type.
package dlfloat_pkg;

    localparam int EXP_W = 6;
    localparam int MAN_W = 9;
    localparam int BIAS  = 31;

    localparam logic [15:0] DLF_ZERO = 16'h0000;
    localparam logic [15:0] DLF_INF  = 16'hFFFF;
    localparam logic [15:0] DLF_MAX  = 16'h7DFE;
    localparam logic [15:0] DLF_MIN  = 16'h0201;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_MUL,
        S_ACC,
        S_OUT
    } state_e;

endpackage

// File: rtl/dlfloat_mac_core.sv
// Combinational DLFloat16 multiply and add with truncating rounding and clamp flags.
module dlfloat_mac_core
    import dlfloat_pkg::*;
(
    input  logic [15:0] mul_a_i,
    input  logic [15:0] mul_b_i,
    output logic [15:0] prod_o,
    output logic        prod_sat_o,
    input  logic [15:0] add_a_i,
    input  logic [15:0] add_b_i,
    output logic [15:0] sum_o,
    output logic        sum_sat_o
);

    localparam int          MSB   = EXP_W + MAN_W;
    localparam logic [6:0]  S_TOP = 7'((1 << EXP_W) - 1 + BIAS);

    logic [6:0]       s;
    logic [10:0]      mph;
    logic [EXP_W-1:0] me;

    always_comb begin
        s   = 7'(mul_a_i[MSB-1:MAN_W]) + 7'(mul_b_i[MSB-1:MAN_W]);
        // Upper 11 bits of the 20-bit hidden-one mantissa product.
        mph = 11'((20'({1'b1, mul_a_i[MAN_W-1:0]}) * 20'({1'b1, mul_b_i[MAN_W-1:0]})) >> MAN_W);
        me  = 6'(s - 7'(BIAS)) + 6'(mph[10]);
        prod_o     = DLF_ZERO;
        prod_sat_o = 1'b0;
        if (mul_a_i == DLF_INF || mul_b_i == DLF_INF) begin
            prod_o = DLF_INF;
        end else if (mul_a_i == DLF_ZERO || mul_b_i == DLF_ZERO) begin
            prod_o = DLF_ZERO;
        end else if (s < 7'(BIAS)) begin
            prod_o     = DLF_MIN;
            prod_sat_o = 1'b1;
        end else if (s == 7'(BIAS)) begin
            prod_o = DLF_ZERO;
        end else if (s > S_TOP) begin
            prod_o     = DLF_MAX;
            prod_sat_o = 1'b1;
        end else if (s == S_TOP) begin
            prod_o = DLF_INF;
        end else begin
            prod_o = {mul_a_i[MSB] ^ mul_b_i[MSB], me, mph[10] ? mph[9:1] : mph[8:0]};
        end
    end

    logic [EXP_W-1:0] ea, eb, el, es, d;
    logic [9:0]       ml, ms, msh, diff;
    logic             sl, ss, a_big;
    logic [10:0]      sum11;
    logic [3:0]       pos, lz;
    logic [MAN_W-1:0] man;
    logic signed [7:0] e;

    always_comb begin
        ea    = add_a_i[MSB-1:MAN_W];
        eb    = add_b_i[MSB-1:MAN_W];
        a_big = (ea > eb) || (ea == eb && add_a_i[MAN_W-1:0] >= add_b_i[MAN_W-1:0]);
        el    = a_big ? ea : eb;
        es    = a_big ? eb : ea;
        ml    = a_big ? {1'b1, add_a_i[MAN_W-1:0]} : {1'b1, add_b_i[MAN_W-1:0]};
        ms    = a_big ? {1'b1, add_b_i[MAN_W-1:0]} : {1'b1, add_a_i[MAN_W-1:0]};
        sl    = a_big ? add_a_i[MSB] : add_b_i[MSB];
        ss    = a_big ? add_b_i[MSB] : add_a_i[MSB];
        d     = el - es;
        msh   = ms >> d;
        sum11 = {1'b0, ml} + {1'b0, msh};
        diff  = ml - msh;
        pos   = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (diff[i]) pos = 4'(i);
        end
        lz    = 4'd9 - pos;
        if (sl == ss) begin
            man = sum11[10] ? sum11[9:1] : sum11[8:0];
            e   = 8'(el) + 8'(sum11[10]);
        end else begin
            man = 9'(diff << lz);
            e   = 8'(el) - 8'(lz);
        end
        sum_o     = DLF_ZERO;
        sum_sat_o = 1'b0;
        if (ea == '0) begin
            sum_o = add_b_i;
        end else if (eb == '0) begin
            sum_o = add_a_i;
        end else if (add_a_i == DLF_INF || add_b_i == DLF_INF) begin
            sum_o = DLF_INF;
        end else if (sl != ss && diff == '0) begin
            sum_o = DLF_ZERO;
        end else if (e > 8'sd62) begin
            sum_o     = DLF_MAX;
            sum_sat_o = 1'b1;
        end else if (e <= 8'sd0) begin
            sum_o     = DLF_MIN;
            sum_sat_o = 1'b1;
        end else begin
            sum_o = {sl, e[5:0], man};
        end
    end

endmodule

// File: rtl/dlfloat_dot_engine.sv
// Streaming DLFloat16 dot-product engine: beat-serial operand intake, MAC, serial result drain.
module dlfloat_dot_engine
    import dlfloat_pkg::*;
#(
    parameter int BUS_W     = 8,
    parameter int MAX_TERMS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             out_sat,
    output logic             busy
);

    localparam int         BEATS    = 16 / BUS_W;
    localparam logic [1:0] LAST_IN  = 2'(2 * BEATS - 1);
    localparam logic [1:0] LAST_OUT = 2'(BEATS - 1);

    state_e      state_q;
    logic [1:0]  beat_q, out_beat_q;
    logic [31:0] op_sr_q;
    logic [15:0] prod_q, acc_q, out_sr_q;
    logic [7:0]  term_q, term_d;
    logic        last_q, sat_q, sat_d;
    logic        in_ready_q, out_valid_q, out_sat_q;
    logic [15:0] mul_res, add_res;
    logic        mul_sat, add_sat;

    dlfloat_mac_core u_core (
        .mul_a_i    (op_sr_q[15:0]),
        .mul_b_i    (op_sr_q[31:16]),
        .prod_o     (mul_res),
        .prod_sat_o (mul_sat),
        .add_a_i    (prod_q),
        .add_b_i    (acc_q),
        .sum_o      (add_res),
        .sum_sat_o  (add_sat)
    );

    assign term_d = term_q + 8'd1;
    assign sat_d  = sat_q | add_sat;

    // Operands arrive LSB beat first; shifting in from the top leaves {B, A} after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            beat_q      <= '0;
            out_beat_q  <= '0;
            op_sr_q     <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            out_sr_q    <= '0;
            term_q      <= '0;
            last_q      <= 1'b0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        op_sr_q <= {in_data, op_sr_q[31:BUS_W]};
                        if (beat_q == LAST_IN) begin
                            beat_q     <= '0;
                            last_q     <= in_last;
                            in_ready_q <= 1'b0;
                            state_q    <= S_MUL;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end
                end
                S_MUL: begin
                    prod_q  <= mul_res;
                    sat_q   <= sat_q | mul_sat;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    acc_q  <= add_res;
                    sat_q  <= sat_d;
                    term_q <= term_d;
                    if (last_q || term_d == 8'(MAX_TERMS)) begin
                        out_valid_q <= 1'b1;
                        out_sr_q    <= add_res;
                        out_sat_q   <= sat_d;
                        out_beat_q  <= '0;
                        state_q     <= S_OUT;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= S_COLLECT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (out_beat_q == LAST_OUT) begin
                            acc_q       <= '0;
                            term_q      <= '0;
                            sat_q       <= 1'b0;
                            last_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_sat_q   <= 1'b0;
                            out_sr_q    <= '0;
                            in_ready_q  <= 1'b1;
                            state_q     <= S_COLLECT;
                        end else begin
                            out_beat_q <= out_beat_q + 2'd1;
                            out_sr_q   <= out_sr_q >> BUS_W;
                        end
                    end
                end
                default: state_q <= S_COLLECT;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_sr_q[BUS_W-1:0];
    assign out_sat   = out_sat_q;
    assign busy      = !(state_q == S_COLLECT && beat_q == 2'd0);

endmodule

// File: tb/tb_dlfloat_dot_engine.sv
// Self-checking bench for dlfloat_dot_engine (BUS_W=8, MAX_TERMS=4) against a value-level reference model.
module tb_dlfloat_dot_engine;

    localparam int MAXT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_last, out_valid, out_ready, out_sat, busy;
    logic [7:0] in_data, out_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mdl_acc;
    bit          mdl_sat;
    int          mdl_terms;
    logic [15:0] exp_res;
    bit          exp_sat;

    dlfloat_dot_engine #(.BUS_W(8), .MAX_TERMS(MAXT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic on integer significands; value = sig * 2^(e - bias - 9).
    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b, output bit sat);
        int s, p, e;
        sat = 1'b0;
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
        s = int'(a[14:9]) + int'(b[14:9]);
        if (s < 31) begin sat = 1'b1; return 16'h0201; end
        if (s == 31) return 16'h0000;
        if (s > 94) begin sat = 1'b1; return 16'h7DFE; end
        if (s == 94) return 16'hFFFF;
        p = ((512 + int'(a[8:0])) * (512 + int'(b[8:0]))) >> 9;
        e = s - 31;
        while (p >= 1024) begin p = p >> 1; e++; end
        return {a[15] ^ b[15], 6'(e), 9'(p)};
    endfunction

    function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b, output bit sat);
        int ea, eb, el, va, vb, r, mag, e;
        bit sg;
        sat = 1'b0;
        ea = int'(a[14:9]);
        eb = int'(b[14:9]);
        if (ea == 0) return b;
        if (eb == 0) return a;
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        el = (ea > eb) ? ea : eb;
        va = (512 + int'(a[8:0])) >> (el - ea);
        vb = (512 + int'(b[8:0])) >> (el - eb);
        if (a[15]) va = -va;
        if (b[15]) vb = -vb;
        r = va + vb;
        if (r == 0) return 16'h0000;
        sg  = (r < 0);
        mag = sg ? -r : r;
        e   = el;
        while (mag >= 1024) begin mag = mag >> 1; e++; end
        while (mag < 512) begin mag = mag << 1; e--; end
        if (e > 62) begin sat = 1'b1; return 16'h7DFE; end
        if (e <= 0) begin sat = 1'b1; return 16'h0201; end
        return {sg, 6'(e), 9'(mag)};
    endfunction

    function automatic logic [15:0] rand_op();
        int r;
        logic [15:0] v;
        r = int'($urandom_range(0, 19));
        v = 16'($urandom);
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'hFFFF;
        if (r == 2) v[14:9] = 6'($urandom_range(55, 62));
        else if (r == 3) v[14:9] = 6'($urandom_range(1, 6));
        else v[14:9] = 6'($urandom_range(26, 36));
        return v;
    endfunction

    task automatic model_reset();
        mdl_acc   = 16'h0000;
        mdl_sat   = 1'b0;
        mdl_terms = 0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Sends one pair, checks the MUL/ACC gap timing, updates the model; eo says a result is due.
    task automatic run_pair(input logic [15:0] a, input logic [15:0] b, input logic last,
                            input logic junk, output bit eo);
        logic [15:0] p;
        bit s1, s2;
        send_beat(a[7:0], junk);
        send_beat(a[15:8], junk);
        send_beat(b[7:0], junk);
        send_beat(b[15:8], last);
        chk("ready_low_1", {31'b0, in_ready}, 32'd0);
        chk("busy_mul", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("ready_low_2", {31'b0, in_ready}, 32'd0);
        chk("valid_low_acc", {31'b0, out_valid}, 32'd0);
        p = m_mul(a, b, s1);
        mdl_acc = m_add(p, mdl_acc, s2);
        mdl_sat = mdl_sat | s1 | s2;
        mdl_terms++;
        eo = last || (mdl_terms == MAXT);
        if (eo) begin
            exp_res = mdl_acc;
            exp_sat = mdl_sat;
            model_reset();
        end
        @(posedge clk); #1;
        chk("out_valid_due", {31'b0, out_valid}, {31'b0, eo});
        if (!eo) chk("ready_back", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic recv_check();
        logic [15:0] r;
        logic        s;
        int n;
        r = '0;
        s = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 200) begin @(negedge clk); n++; end
            chk("out_valid_wait", {31'b0, out_valid}, 32'd1);
            r[i*8 +: 8] = out_data;
            s = out_sat;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("result", {16'b0, r}, {16'b0, exp_res});
        chk("result_sat", {31'b0, s}, {31'b0, exp_sat});
        chk("ready_after_drain", {31'b0, in_ready}, 32'd1);
        chk("valid_after_drain", {31'b0, out_valid}, 32'd0);
        chk("idle_after_drain", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, {24'b0, out_data}, 32'd0);
        chk({tag, "_out_sat"}, {31'b0, out_sat}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        bit eo;
        logic [7:0] held;
        logic [15:0] a, b;
        int len;

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_post_reset", {31'b0, in_ready}, 32'd1);

        // 1*2 + 1.5*1 = 3.5
        run_pair(16'h3E00, 16'h4000, 1'b0, 1'b1, eo);
        run_pair(16'h3F00, 16'h3E00, 1'b1, 1'b0, eo);
        chk("dot35_first_beat", {24'b0, out_data}, 32'h80);
        chk("dot35_model", {16'b0, exp_res}, 32'h4180);
        recv_check();

        run_pair(16'h7C00, 16'h7C00, 1'b1, 1'b0, eo);
        chk("ovf_model", {16'b0, exp_res}, 32'h7DFE);
        recv_check();

        run_pair(16'h0000, 16'h4000, 1'b1, 1'b0, eo);
        recv_check();

        run_pair(16'hFFFF, 16'h3E00, 1'b0, 1'b0, eo);
        run_pair(16'h3E00, 16'h3E00, 1'b1, 1'b0, eo);
        chk("inf_model", {16'b0, exp_res}, 32'hFFFF);
        recv_check();

        // Four unit terms reach MAX_TERMS without in_last: 4.0, then a fresh 1.0.
        for (int k = 0; k < 4; k++) run_pair(16'h3E00, 16'h3E00, 1'b0, 1'b0, eo);
        chk("maxterm_model", {16'b0, exp_res}, 32'h4200);
        recv_check();
        run_pair(16'h3E00, 16'h3E00, 1'b1, 1'b0, eo);
        recv_check();

        // Backpressure: output holds and nothing is accepted.
        run_pair(16'h3F00, 16'h4000, 1'b1, 1'b0, eo);
        held = out_data;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_data_stable", {24'b0, out_data}, {24'b0, held});
            chk("bp_ready_low", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("bp_valid_held", {31'b0, out_valid}, 32'd1);
        recv_check();

        // Reset in the middle of an operand discards it.
        send_beat(8'h00, 1'b0);
        send_beat(8'h3E, 1'b0);
        chk("busy_partial", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        run_pair(16'h3E00, 16'h3E00, 1'b1, 1'b0, eo);
        chk("after_reset_model", {16'b0, exp_res}, 32'h3E00);
        recv_check();

        for (int t = 0; t < 25; t++) begin
            len = int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) begin
                a = rand_op();
                b = rand_op();
                run_pair(a, b, k == len - 1, 1'($urandom_range(0, 1)), eo);
                if (eo) recv_check();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
